// File: rtl/mem_responder.sv
// Wait-stated, address-windowed 32-bit word RAM bank for the CPU memory port.
// Optional per-word even parity: define MEM_RESP_PARITY_EN (adds inj_perr, perr).
`timescale 1ns/1ps
module mem_responder #(
  parameter int          DEPTH       = 2048,
  parameter logic [14:0] BASE        = 15'h0800,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readstart,
  input  logic        wCPU,
  input  logic [14:0] addrCPU,
  input  logic [31:0] fromCPU,
`ifdef MEM_RESP_PARITY_EN
  input  logic        inj_perr,
  output logic        perr,
`endif
  output logic [31:0] toCPU,
  output logic        readrdy,
  output logic        saverdy,
  output logic        busy,
  output logic        hit
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
`ifdef MEM_RESP_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [31:0]     data_q;
  logic            op_wr;
  logic [14:0]     off_in;
  logic            in_win;
  logic            wr_en;
  logic            rd_en;
  logic [MW-1:0]   wdata;
  logic [MW-1:0]   rdata;
  logic [MW-1:0]   mem [DEPTH];

  // 15-bit wrap makes addresses below BASE land far outside the window
  assign off_in = addrCPU - BASE;
  assign in_win = {1'b0, off_in} < DEPTH_W;
  assign wr_en  = (state == ACCESS) && op_wr && hit;
  assign rd_en  = (state == ACCESS) && !op_wr;

`ifdef MEM_RESP_PARITY_EN
  logic inj_pend;
  assign wdata = {(^data_q) ^ inj_pend, data_q};
`else
  assign wdata = data_q;
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[idx_q] <= wdata;
    if (rd_en)
      rdata <= mem[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      op_wr   <= 1'b0;
      toCPU   <= '0;
      readrdy <= 1'b0;
      saverdy <= 1'b0;
      busy    <= 1'b0;
      hit     <= 1'b0;
`ifdef MEM_RESP_PARITY_EN
      perr     <= 1'b0;
      inj_pend <= 1'b0;
`endif
    end else begin
      readrdy <= 1'b0;
      saverdy <= 1'b0;
`ifdef MEM_RESP_PARITY_EN
      perr <= 1'b0;
      if ((state == ACCESS) && op_wr)
        inj_pend <= inj_perr;
      else if (inj_perr)
        inj_pend <= 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (readstart || wCPU) begin
            idx_q  <= off_in[AW-1:0];
            data_q <= fromCPU;
            op_wr  <= wCPU;
            hit    <= in_win;
            busy   <= 1'b1;
            cnt    <= '0;
            state  <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (cnt == WS_LAST)
            state <= ACCESS;
          else
            cnt <= cnt + 4'd1;
        end
        ACCESS: begin
          if (op_wr) begin
            saverdy <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          toCPU   <= hit ? rdata[31:0] : 32'h0;
          readrdy <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
`ifdef MEM_RESP_PARITY_EN
          perr <= hit && (^rdata);
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: WAIT_STATES=2 and WAIT_STATES=0 instances.
// Expected handshakes are queued at request time and checked as rdy pulses appear.
`timescale 1ns/1ps
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rs2, wc2, rs0, wc0;
  logic [14:0] a2, a0;
  logic [31:0] d2, d0, to2, to0;
  logic        rr2, sr2, busy2, hit2;
  logic        rr0, sr0, busy0, hit0;
  logic        inj2, inj0, perr2, perr0;

  mem_responder #(.WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst),
    .readstart(rs2), .wCPU(wc2),
    .addrCPU(a2), .fromCPU(d2),
`ifdef MEM_RESP_PARITY_EN
    .inj_perr(inj2), .perr(perr2),
`endif
    .toCPU(to2), .readrdy(rr2),
    .saverdy(sr2), .busy(busy2), .hit(hit2)
  );

  mem_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst),
    .readstart(rs0), .wCPU(wc0),
    .addrCPU(a0), .fromCPU(d0),
`ifdef MEM_RESP_PARITY_EN
    .inj_perr(inj0), .perr(perr0),
`endif
    .toCPU(to0), .readrdy(rr0),
    .saverdy(sr0), .busy(busy0), .hit(hit0)
  );

`ifndef MEM_RESP_PARITY_EN
  assign perr2 = 1'b0;
  assign perr0 = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          rd;
    bit          wr;
    logic [31:0] data;
    logic        hit;
    logic        perr;
  } ev_t;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  exp2[$];
  ev_t  exp0[$];
  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  bit          bp0 [int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_win(input logic [14:0] a);
    return (a >= 15'h0800) && (a <= 15'h0FFF);
  endfunction

  always @(negedge clk) begin
    if (rr2 || sr2) begin
      ev_t e;
      total++;
      if (exp2.size() == 0) begin
        bad++;
        $display("FAIL u2_unexpected rr=%0b sr=%0b cyc=%0d required=none",
                 rr2, sr2, cyc);
      end else begin
        e = exp2.pop_front();
        if (rr2 !== e.rd || sr2 !== e.wr || cyc !== e.cyc ||
            hit2 !== e.hit || (e.rd && to2 !== e.data)) begin
          bad++;
          $display("FAIL u2_event got rr=%0b sr=%0b cyc=%0d hit=%0b d=%h required rr=%0b sr=%0b cyc=%0d hit=%0b d=%h",
                   rr2, sr2, cyc, hit2, to2, e.rd, e.wr, e.cyc, e.hit, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rr0 || sr0) begin
      ev_t e;
      bit  pok;
      total++;
      if (exp0.size() == 0) begin
        bad++;
        $display("FAIL u0_unexpected rr=%0b sr=%0b cyc=%0d required=none",
                 rr0, sr0, cyc);
      end else begin
        e = exp0.pop_front();
`ifdef MEM_RESP_PARITY_EN
        pok = (perr0 === e.perr);
`else
        pok = 1'b1;
`endif
        if (rr0 !== e.rd || sr0 !== e.wr || cyc !== e.cyc ||
            hit0 !== e.hit || (e.rd && to0 !== e.data) || !pok) begin
          bad++;
          $display("FAIL u0_event got rr=%0b sr=%0b cyc=%0d hit=%0b d=%h perr=%0b required rr=%0b sr=%0b cyc=%0d hit=%0b d=%h perr=%0b",
                   rr0, sr0, cyc, hit0, to0, perr0,
                   e.rd, e.wr, e.cyc, e.hit, e.data, e.perr);
        end
      end
    end
  end

  task automatic req(input bit sel0, input bit r, input bit w,
                     input logic [14:0] a, input logic [31:0] d,
                     input bit inj, output int e0);
    ev_t e;
    int  ws;
    @(negedge clk);
    if (sel0) begin
      rs0 = r; wc0 = w; a0 = a; d0 = d; inj0 = inj;
    end else begin
      rs2 = r; wc2 = w; a2 = a; d2 = d; inj2 = inj;
    end
    e0 = cyc + 1;
    ws = sel0 ? 0 : 2;
    e.hit  = in_win(a);
    e.perr = 1'b0;
    e.data = 32'h0;
    if (w) begin
      e.cyc = e0 + ws + 1;
      e.rd  = 1'b0;
      e.wr  = 1'b1;
      if (in_win(a)) begin
        if (sel0) begin
          m0[int'(a)]  = d;
          bp0[int'(a)] = inj;
        end else begin
          m2[int'(a)] = d;
        end
      end
    end else begin
      e.cyc = e0 + ws + 2;
      e.rd  = 1'b1;
      e.wr  = 1'b0;
      if (in_win(a)) begin
        e.data = sel0 ? m0[int'(a)] : m2[int'(a)];
        if (sel0 && bp0.exists(int'(a)))
          e.perr = bp0[int'(a)];
      end
    end
    if (sel0) exp0.push_back(e);
    else      exp2.push_back(e);
    @(negedge clk);
    rs0 = 1'b0; wc0 = 1'b0; inj0 = 1'b0;
    rs2 = 1'b0; wc2 = 1'b0; inj2 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel0);
    for (int i = 0; i < 40; i++) begin
      if ((sel0 ? exp0.size() : exp2.size()) == 0) break;
      @(negedge clk);
      #1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({to2, rr2, sr2, busy2, hit2} !== 36'h0) begin
      bad++;
      $display("FAIL reset_u2 got to=%h rr=%0b sr=%0b busy=%0b hit=%0b required all 0",
               to2, rr2, sr2, busy2, hit2);
    end
    total++;
    if ({to0, rr0, sr0, busy0, hit0} !== 36'h0) begin
      bad++;
      $display("FAIL reset_u0 got to=%h rr=%0b sr=%0b busy=%0b hit=%0b required all 0",
               to0, rr0, sr0, busy0, hit0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int e0;
    req(1'b0, 1'b0, 1'b1, 15'h0800, 32'hDEADBEEF, 1'b0, e0);
    total++;
    if (busy2 !== 1'b1) begin
      bad++;
      $display("FAIL write_busy got=%0b required=1", busy2);
    end
    wait_idle(1'b0);
    total++;
    if (exp2.size() != 0) begin
      bad++;
      $display("FAIL write_drain pending=%0d required=0", exp2.size());
      exp2.delete();
    end
  endtask

  task automatic test_read();
    int e0;
    req(1'b0, 1'b1, 1'b0, 15'h0800, 32'h0, 1'b0, e0);
    wait_idle(1'b0);
    total++;
    if (exp2.size() != 0) begin
      bad++;
      $display("FAIL read_drain pending=%0d required=0", exp2.size());
      exp2.delete();
    end
    total++;
    if (hit2 !== 1'b1) begin
      bad++;
      $display("FAIL read_hit got=%0b required=1", hit2);
    end
    repeat (10) @(negedge clk);
    total++;
    if (to2 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read_hold got=%h required=deadbeef", to2);
    end
  endtask

  task automatic test_window();
    int e0;
    req(1'b0, 1'b0, 1'b1, 15'h0FFF, 32'hA5A5A5A5, 1'b0, e0);
    wait_idle(1'b0);
    req(1'b0, 1'b1, 1'b0, 15'h0000, 32'h0, 1'b0, e0);
    wait_idle(1'b0);
    total++;
    if (hit2 !== 1'b0 || to2 !== 32'h0) begin
      bad++;
      $display("FAIL window_miss got hit=%0b to=%h required hit=0 to=0",
               hit2, to2);
    end
    req(1'b0, 1'b0, 1'b1, 15'h1000, 32'h11111111, 1'b0, e0);
    wait_idle(1'b0);
    req(1'b0, 1'b1, 1'b0, 15'h0FFF, 32'h0, 1'b0, e0);
    wait_idle(1'b0);
    total++;
    if (exp2.size() != 0 || to2 !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL window_edge got to=%h pending=%0d required=a5a5a5a5",
               to2, exp2.size());
      exp2.delete();
    end
  endtask

  task automatic test_collision();
    int e0;
    req(1'b0, 1'b1, 1'b1, 15'h0801, 32'h12345678, 1'b0, e0);
    wait_idle(1'b0);
    req(1'b0, 1'b1, 1'b0, 15'h0801, 32'h0, 1'b0, e0);
    @(negedge clk);
    rs2 = 1'b1;
    @(negedge clk);
    total++;
    if (busy2 !== 1'b1) begin
      bad++;
      $display("FAIL collide_busy got=%0b required=1", busy2);
    end
    @(negedge clk);
    rs2 = 1'b0;
    wait_idle(1'b0);
    total++;
    if (exp2.size() != 0 || to2 !== 32'h12345678) begin
      bad++;
      $display("FAIL collide_read got to=%h pending=%0d required=12345678",
               to2, exp2.size());
      exp2.delete();
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    req(1'b0, 1'b1, 1'b0, 15'h0800, 32'h0, 1'b0, e0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp2.delete();
    total++;
    if ({to2, rr2, sr2, busy2, hit2} !== 36'h0) begin
      bad++;
      $display("FAIL midrst_out got to=%h rr=%0b sr=%0b busy=%0b hit=%0b required all 0",
               to2, rr2, sr2, busy2, hit2);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    req(1'b0, 1'b1, 1'b0, 15'h0800, 32'h0, 1'b0, e0);
    wait_idle(1'b0);
    total++;
    if (exp2.size() != 0 || to2 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL midrst_next got to=%h pending=%0d required=deadbeef",
               to2, exp2.size());
      exp2.delete();
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    req(1'b1, 1'b0, 1'b1, 15'h0802, 32'hCAFEF00D, 1'b0, e0);
    req(1'b1, 1'b0, 1'b1, 15'h0803, 32'h0BADC0DE, 1'b0, e0);
    req(1'b1, 1'b1, 1'b0, 15'h0802, 32'h0, 1'b0, e0);
    @(negedge clk);
    req(1'b1, 1'b1, 1'b0, 15'h0803, 32'h0, 1'b0, e0);
    wait_idle(1'b1);
    total++;
    if (exp0.size() != 0 || to0 !== 32'h0BADC0DE) begin
      bad++;
      $display("FAIL b2b_last got to=%h pending=%0d required=0badc0de",
               to0, exp0.size());
      exp0.delete();
    end
  endtask

`ifdef MEM_RESP_PARITY_EN
  task automatic test_parity();
    int e0;
    req(1'b1, 1'b0, 1'b1, 15'h0804, 32'h0F0F0F0F, 1'b1, e0);
    req(1'b1, 1'b0, 1'b1, 15'h0805, 32'h00000007, 1'b0, e0);
    req(1'b1, 1'b1, 1'b0, 15'h0804, 32'h0, 1'b0, e0);
    @(negedge clk);
    req(1'b1, 1'b1, 1'b0, 15'h0805, 32'h0, 1'b0, e0);
    @(negedge clk);
    req(1'b1, 1'b1, 1'b0, 15'h0000, 32'h0, 1'b0, e0);
    wait_idle(1'b1);
    total++;
    if (exp0.size() != 0 || perr0 !== 1'b0) begin
      bad++;
      $display("FAIL parity_drain got perr=%0b pending=%0d required 0",
               perr0, exp0.size());
      exp0.delete();
    end
  endtask
`endif

  initial begin
    rs2 = 1'b0; wc2 = 1'b0; a2 = '0; d2 = '0; inj2 = 1'b0;
    rs0 = 1'b0; wc0 = 1'b0; a0 = '0; d0 = '0; inj0 = 1'b0;
    rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_window();
    test_collision();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_RESP_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU memory controller's request interface.
- Services the controller's 32-bit word reads (readstart -> readrdy + toCPU) and writes (wCPU -> saverdy) from an internal synchronous word RAM.
- Decodes an address window and inserts a programmable number of wait states.
- Sits between the CPU memory port and the ROM/RAM selection logic as one addressable memory bank.

Parameters:
- DEPTH, 2048, number of 32-bit words in the bank (power of two, max 16384).
- BASE, 15'h0800, first word address of the window; window is BASE .. BASE+DEPTH-1, BASE aligned to DEPTH.
- WAIT_STATES, 2, extra cycles inserted before each access completes (0..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- readstart  in  1  read request strobe from memory controller
- wCPU  in  1  write request strobe from memory controller
- addrCPU  in  15  word address
- fromCPU  in  32  write data
- toCPU  out  32  read data
- readrdy  out  1  read complete, one-cycle pulse
- saverdy  out  1  write complete, one-cycle pulse
- busy  out  1  access in progress, new requests ignored
- hit  out  1  registered: last accepted address was inside the window

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: toCPU=0, readrdy=0, saverdy=0, busy=0, hit=0, state=IDLE, wait counter=0. RAM contents are not reset.
- States are IDLE, WAIT, ACCESS, DONE.
- IDLE: request sampled at rising edge E0 when readstart|wCPU.
  - Capture addr, data and op; set busy=1.
  - Go to WAIT if WAIT_STATES>0, else ACCESS.
- Simultaneous readstart and wCPU: write wins, read is dropped, only saverdy is returned.
- WAIT: counter counts 0..WAIT_STATES-1, then goes to ACCESS. Requests arriving while busy=1 are ignored, not queued.
- ACCESS, write:
  - RAM[addr-BASE] <= data if in window.
  - saverdy=1 for the next cycle.
  - Go to IDLE with busy=0. Write latency is E0+WAIT_STATES+1.
- ACCESS, read:
  - Synchronous RAM read issued; go to DONE.
- DONE:
  - toCPU <= RAM data; readrdy=1 for exactly one cycle; busy=0.
  - Read latency: readrdy high after edge E0+WAIT_STATES+2.
- toCPU holds its value until the next read completes; writes do not disturb it.
- Out-of-window address:
  - Full handshake still completes with identical timing, so the controller never hangs.
  - Read returns 32'h0; write is discarded; hit=0.
- Window check: (addrCPU - BASE) < DEPTH, done on the captured address, 15-bit unsigned. Address wrap below BASE falls out of window.
- A new request may be accepted in the cycle after readrdy or saverdy.
- Reset mid-access:
  - State returns to IDLE, pending op is aborted, no rdy pulse is emitted.
  - An in-progress RAM write at the same edge is not guaranteed.
- readrdy and saverdy are never high together and never high for two consecutive cycles for a single request.

Optional Feature:
- Macro MEM_RESP_PARITY_EN.
- When defined:
  - RAM stores one even-parity bit per word, computed on write.
  - On read completion, output port perr (1 bit, reset 0) pulses with readrdy if the recomputed parity mismatches.
  - Out-of-window reads give perr=0.
  - A test-only input inj_perr (1 bit) inverts the stored parity bit on the next write.
- When undefined: no parity storage; no perr or inj_perr ports.

Test Plan:
- Reset, then write addr 15'h0800 data 32'hDEADBEEF, WAIT_STATES=2 -> saverdy single pulse 3 cycles after request edge; readrdy stays 0.
- Read 15'h0800 -> readrdy pulse 4 cycles after request edge, toCPU=32'hDEADBEEF, hit=1; toCPU still 32'hDEADBEEF 10 cycles later.
- Read 15'h0000 (outside window) -> readrdy after 4 cycles, toCPU=0, hit=0. Write to 15'h1000 is discarded; the later read of 15'h0FFF is unaffected.
- readstart and wCPU together at addr 15'h0801, data 32'h12345678 -> only saverdy; following read returns 32'h12345678. Extra readstart pulses while busy=1 produce no extra readrdy.
- Assert rst during WAIT of a read -> all outputs 0 immediately; no readrdy after rst release. Next read completes normally.
- WAIT_STATES=0: back-to-back writes and reads of 15'h0802/15'h0803 -> saverdy at +1, readrdy at +2. With MEM_RESP_PARITY_EN and inj_perr on write -> perr=1 with readrdy.
